// File: rtl/wbarb.sv
// Round-robin arbiter sharing one classic-cycle wishbone slave bus between
// NMASTER masters, with a watchdog that force-acks cycles the slave never answers.
//
// state   | meaning
// IDLE    | no slave cycle in progress, arbitrating
// BUSY    | slave cycle running, grant fixed in last_grant
module wbarb #(
    parameter int          NMASTER = 2,
    parameter int          TIMEOUT = 64,
    parameter logic [7:0]  TMO_DAT = 8'hFF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NMASTER-1:0]      m_stb_i,
    input  logic [NMASTER-1:0]      m_we_i,
    input  logic [16*NMASTER-1:0]   m_adr_i,
    input  logic [8*NMASTER-1:0]    m_dat_i,
    output logic [NMASTER-1:0]      m_ack_o,
    output logic [7:0]              m_dat_o,
    output logic                    s_stb_o,
    output logic                    s_cyc_o,
    output logic                    s_we_o,
    output logic [15:0]             s_adr_o,
    output logic [7:0]              s_dat_o,
    input  logic [7:0]              s_dat_i,
    input  logic                    s_ack_i,
    output logic                    tmo_o,
    output logic [7:0]              tmo_cnt_o
);

    localparam int GW = (NMASTER > 1) ? $clog2(NMASTER) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    logic           state;
    logic [GW-1:0]  last_grant;
    logic [GW-1:0]  grant_nxt;
    logic [WW-1:0]  wdog;
    logic           tmo_hit;
    logic           sel_we;
    logic [15:0]    sel_adr;
    logic [7:0]     sel_dat;
    int             idx;

    // Scan from the farthest candidate to the nearest so the nearest set bit after last_grant wins.
    always_comb begin
        grant_nxt = last_grant;
        idx       = 0;
        for (int i = NMASTER; i >= 1; i--) begin
            idx = (int'(last_grant) + i) % NMASTER;
            if (m_stb_i[idx]) grant_nxt = GW'(idx);
        end
    end

    always_comb begin
        sel_we  = 1'b0;
        sel_adr = '0;
        sel_dat = '0;
        for (int k = 0; k < NMASTER; k++) begin
            if (grant_nxt == GW'(k)) begin
                sel_we  = m_we_i[k];
                sel_adr = m_adr_i[16*k +: 16];
                sel_dat = m_dat_i[8*k +: 8];
            end
        end
    end

    assign tmo_hit = (state == ST_BUSY) && (wdog == WW'(TIMEOUT-1)) && !s_ack_i;
    assign m_dat_o = tmo_hit ? TMO_DAT : s_dat_i;
    assign s_cyc_o = s_stb_o;

    always_comb begin
        m_ack_o = '0;
        if (state == ST_BUSY) begin
            for (int k = 0; k < NMASTER; k++) begin
                if (last_grant == GW'(k)) m_ack_o[k] = s_ack_i | tmo_hit;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_grant <= GW'(NMASTER-1);
            wdog       <= '0;
            s_stb_o    <= 1'b0;
            s_we_o     <= 1'b0;
            s_adr_o    <= '0;
            s_dat_o    <= '0;
            tmo_o      <= 1'b0;
            tmo_cnt_o  <= '0;
        end else begin
            tmo_o <= tmo_hit;
            if (tmo_hit && (tmo_cnt_o != 8'hFF)) tmo_cnt_o <= tmo_cnt_o + 8'd1;
            case (state)
                ST_IDLE: begin
                    if (|m_stb_i) begin
                        state      <= ST_BUSY;
                        last_grant <= grant_nxt;
                        wdog       <= '0;
                        s_stb_o    <= 1'b1;
                        s_we_o     <= sel_we;
                        s_adr_o    <= sel_adr;
                        s_dat_o    <= sel_dat;
                    end
                end
                default: begin
                    // Finishing master still shows stb, so return to IDLE without regranting.
                    if (s_ack_i || tmo_hit) begin
                        state   <= ST_IDLE;
                        s_stb_o <= 1'b0;
                    end else begin
                        wdog <= wdog + WW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wbarb.sv
// Directed bench for wbarb: single read, alternating grants, watchdog
// timeout, ack/timeout race, reset mid-cycle and counter saturation.
module tb_wbarb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  m_stb_i, m_we_i;
    logic [31:0] m_adr_i;
    logic [15:0] m_dat_i;
    logic [1:0]  m_ack_o;
    logic [7:0]  m_dat_o;
    logic        s_stb_o, s_cyc_o, s_we_o;
    logic [15:0] s_adr_o;
    logic [7:0]  s_dat_o, s_dat_i;
    logic        s_ack_i;
    logic        tmo_o;
    logic [7:0]  tmo_cnt_o;

    int n_cmp = 0;
    int n_err = 0;
    int pulses;
    int budget;

    wbarb dut (
        .clk(clk), .rst_n(rst_n),
        .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
        .m_ack_o(m_ack_o), .m_dat_o(m_dat_o),
        .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .tmo_o(tmo_o), .tmo_cnt_o(tmo_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        m_stb_i = 2'b00;
        m_we_i  = 2'b00;
        m_adr_i = '0;
        m_dat_i = '0;
        s_dat_i = 8'h00;
        s_ack_i = 1'b0;
        repeat (3) tick();
        chk("rst_stb", {31'd0, s_stb_o}, 32'd0);
        chk("rst_we", {31'd0, s_we_o}, 32'd0);
        chk("rst_adr", {16'd0, s_adr_o}, 32'd0);
        chk("rst_dat", {24'd0, s_dat_o}, 32'd0);
        chk("rst_tmo", {31'd0, tmo_o}, 32'd0);
        chk("rst_cnt", {24'd0, tmo_cnt_o}, 32'd0);
        chk("rst_ack", {30'd0, m_ack_o}, 32'd0);
        rst_n = 1'b1;

        // single read by M0, slave acks two clocks after stb
        m_stb_i = 2'b01;
        m_adr_i = {16'h0000, 16'h0102};
        tick();
        chk("rd_stb", {30'd0, s_stb_o, s_cyc_o}, 32'h3);
        chk("rd_adr", {16'd0, s_adr_o}, 32'h0102);
        chk("rd_we", {31'd0, s_we_o}, 32'd0);
        chk("rd_ack_early0", {30'd0, m_ack_o}, 32'd0);
        tick();
        chk("rd_ack_early1", {30'd0, m_ack_o}, 32'd0);
        tick();
        s_ack_i = 1'b1;
        s_dat_i = 8'h3C;
        #1;
        chk("rd_ack", {30'd0, m_ack_o}, 32'h1);
        chk("rd_data", {24'd0, m_dat_o}, 32'h3C);
        tick();
        s_ack_i = 1'b0;
        m_stb_i = 2'b00;
        #1;
        chk("rd_ack_after", {30'd0, m_ack_o}, 32'd0);
        chk("rd_stb_after", {31'd0, s_stb_o}, 32'd0);

        // both masters request, slave acks immediately: last grant was M0 so M1 first
        m_stb_i = 2'b11;
        m_adr_i = {16'h1111, 16'h1000};
        s_ack_i = 1'b1;
        tick();
        chk("alt_adr_a", {16'd0, s_adr_o}, 32'h1111);
        chk("alt_ack_a", {30'd0, m_ack_o}, 32'h2);
        tick();
        chk("alt_idle_a", {30'd0, s_stb_o, m_ack_o[0]}, 32'd0);
        chk("alt_idle_ack_a", {30'd0, m_ack_o}, 32'd0);
        tick();
        chk("alt_adr_b", {16'd0, s_adr_o}, 32'h1000);
        chk("alt_ack_b", {30'd0, m_ack_o}, 32'h1);
        tick();
        chk("alt_idle_b", {31'd0, s_stb_o}, 32'd0);
        tick();
        chk("alt_adr_c", {16'd0, s_adr_o}, 32'h1111);
        tick();
        tick();
        chk("alt_adr_d", {16'd0, s_adr_o}, 32'h1000);
        chk("alt_ack_d", {30'd0, m_ack_o}, 32'h1);
        m_stb_i = 2'b00;
        tick();
        s_ack_i = 1'b0;
        #1;
        chk("alt_end_stb", {31'd0, s_stb_o}, 32'd0);

        // M1 write with no slave ack: watchdog fires at wdog=63
        m_stb_i = 2'b10;
        m_we_i  = 2'b10;
        m_adr_i = {16'h2000, 16'h0000};
        m_dat_i = {8'hA5, 8'h00};
        s_dat_i = 8'h55;
        tick();
        chk("wr_we", {31'd0, s_we_o}, 32'd1);
        chk("wr_adr", {16'd0, s_adr_o}, 32'h2000);
        chk("wr_dat", {24'd0, s_dat_o}, 32'hA5);
        repeat (62) tick();
        chk("tmo_ack_early", {30'd0, m_ack_o}, 32'd0);
        tick();
        chk("tmo_ack", {30'd0, m_ack_o}, 32'h2);
        chk("tmo_data", {24'd0, m_dat_o}, 32'hFF);
        chk("tmo_pulse_early", {31'd0, tmo_o}, 32'd0);
        tick();
        m_stb_i = 2'b00;
        m_we_i  = 2'b00;
        #1;
        chk("tmo_pulse", {31'd0, tmo_o}, 32'd1);
        chk("tmo_cnt1", {24'd0, tmo_cnt_o}, 32'd1);
        chk("tmo_stb_drop", {31'd0, s_stb_o}, 32'd0);
        tick();
        chk("tmo_pulse_end", {31'd0, tmo_o}, 32'd0);

        // real ack arriving on the watchdog's last clock wins
        m_stb_i = 2'b01;
        m_adr_i = {16'h0000, 16'h3000};
        tick();
        chk("race_adr", {16'd0, s_adr_o}, 32'h3000);
        repeat (63) tick();
        s_ack_i = 1'b1;
        s_dat_i = 8'h77;
        #1;
        chk("race_ack", {30'd0, m_ack_o}, 32'h1);
        chk("race_data", {24'd0, m_dat_o}, 32'h77);
        tick();
        s_ack_i = 1'b0;
        m_stb_i = 2'b00;
        #1;
        chk("race_tmo", {31'd0, tmo_o}, 32'd0);
        chk("race_cnt", {24'd0, tmo_cnt_o}, 32'd1);

        // reset during BUSY; afterwards M0 must win despite last grant being M0
        m_stb_i = 2'b01;
        m_adr_i = {16'h4111, 16'h4000};
        tick();
        chk("rb_busy", {31'd0, s_stb_o}, 32'd1);
        rst_n   = 1'b0;
        m_stb_i = 2'b11;
        #1;
        chk("rb_ack_in_rst", {30'd0, m_ack_o}, 32'd0);
        tick();
        chk("rb_stb_drop", {31'd0, s_stb_o}, 32'd0);
        chk("rb_ack_after", {30'd0, m_ack_o}, 32'd0);
        chk("rb_cnt_clr", {24'd0, tmo_cnt_o}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rb_grant_m0", {16'd0, s_adr_o}, 32'h4000);
        s_ack_i = 1'b1;
        #1;
        chk("rb_ack_m0", {30'd0, m_ack_o}, 32'h1);
        tick();
        s_ack_i = 1'b0;
        m_stb_i = 2'b01;

        // repeated forced timeouts saturate the counter
        pulses = 0;
        budget = 0;
        while (pulses < 300 && budget < 25000) begin
            tick();
            budget++;
            if (tmo_o) begin
                pulses++;
                if (pulses == 254) chk("sat_cnt_254", {24'd0, tmo_cnt_o}, 32'hFE);
                if (pulses == 256) chk("sat_cnt_256", {24'd0, tmo_cnt_o}, 32'hFF);
            end
        end
        chk("sat_budget", pulses, 32'd300);
        chk("sat_cnt", {24'd0, tmo_cnt_o}, 32'hFF);
        m_stb_i = 2'b00;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
